// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, FSM states
// and the compression-function logic primitives.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-level bus between the message-schedule generator / controller and the
// SHA-256 compression core.
interface sha256_compress_if;
  logic         start;
  logic         first_block;
  logic [31:0]  w_in;
  logic         w_valid;
  logic         w_req;
  logic         busy;
  logic         done;
  logic [255:0] digest;

  modport master (
    output start, first_block, w_in, w_valid,
    input  w_req, busy, done, digest
  );

  modport slave (
    input  start, first_block, w_in, w_valid,
    output w_req, busy, done, digest
  );
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant for the current round.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  i_addr,
  output logic [31:0] o_data
);
  assign o_data = K_TABLE[i_addr];
endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression core: one round per accepted schedule word, then the
// chaining add into H0..H7.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input logic              clk,
  input logic              reset,
  sha256_compress_if.slave bus
);

  localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_wv [8];  // working variables a..h
  logic [31:0] r_hv [8];  // chaining value H0..H7

  logic [31:0] w_k;
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic        w_load;
  logic        w_step;
  logic        w_final;

  sha256_k_rom u_k_rom (
    .i_addr (r_cnt),
    .o_data (w_k)
  );

  assign w_load  = (r_state == ST_IDLE) && bus.start;
  assign w_step  = (r_state == ST_ROUND) && bus.w_valid;
  assign w_final = (r_state == ST_FINAL);

  assign w_t1 = r_wv[7] + big_sigma1(r_wv[4]) + ch(r_wv[4], r_wv[5], r_wv[6])
              + w_k + bus.w_in;
  assign w_t2 = big_sigma0(r_wv[0]) + maj(r_wv[0], r_wv[1], r_wv[2]);

  assign bus.w_req  = (r_state == ST_ROUND);
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.digest = {r_hv[0], r_hv[1], r_hv[2], r_hv[3],
                       r_hv[4], r_hv[5], r_hv[6], r_hv[7]};

  // Control: state, round counter, registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_ROUND;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (bus.w_valid) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == LAST_RND) r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: working-variable load/round shift and chaining add
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_wv[i] <= '0;
        r_hv[i] <= IV[i];
      end
    end else begin
      if (w_load) begin
        for (int i = 0; i < 8; i++) begin
          r_wv[i] <= bus.first_block ? IV[i] : r_hv[i];
          if (bus.first_block) r_hv[i] <= IV[i];
        end
      end else if (w_step) begin
        r_wv[0] <= w_t1 + w_t2;
        r_wv[1] <= r_wv[0];
        r_wv[2] <= r_wv[1];
        r_wv[3] <= r_wv[2];
        r_wv[4] <= r_wv[3] + w_t1;
        r_wv[5] <= r_wv[4];
        r_wv[6] <= r_wv[5];
        r_wv[7] <= r_wv[6];
      end
      if (w_final) begin
        for (int i = 0; i < 8; i++) r_hv[i] <= r_hv[i] + r_wv[i];
      end
    end
  end

endmodule
